multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
Sequencing controller for the next-generation multi-cycle RV32I-subset CPU. The datapath is built from the existing PC, register file, ALU, ALU control, sign extension and muxes, with one shared instruction/data memory and IR/ALUOut holding registers.
A Moore FSM steps each instruction through fetch, decode, execute, memory and write-back. It drives every datapath select and enable, and handshakes with the shared memory through MemReq/MemReady.
Supported instructions: R-type ALU, I-type ALU, LW, SW, BEQ. Anything else, or a memory timeout, halts the core.

Parameters:
MAX_WAIT, 15, max consecutive MemReady-low cycles tolerated in one memory state before timeout (1..255)
WAITW, 8, width of the wait counter

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  reset, synchronous and active-high
Opcode  input  7  IR[6:0]; valid from DECODE onward
Funct3  input  3  IR[14:12]
Zero  input  1  ALU zero flag
MemReady  input  1  memory completes the current access this cycle
MemReq  output  1  memory access request
MemRW  output  1  0 read, 1 write
IorD  output  1  memory address select: 0 PC, 1 ALUOut
IRWrite  output  1  load IR from memory read data
PCWrite  output  1  load PC
PCSrc  output  1  PC source: 0 ALU result, 1 ALUOut
ALUSrcA  output  1  0 PC, 1 RD1
ALUSrcB  output  2  00 RD2, 01 constant 4, 10 sign-extended immediate
ALUOp  output  2  to ALU control: 00 add, 01 sub, 10 R-type funct, 11 I-type funct (funct7 ignored)
RegWrite  output  1  register file write enable
MemtoReg  output  1  write-data select: 0 ALUOut, 1 memory data
State  output  4  current state code, for debug
Halt  output  1  core halted
Illegal  output  1  sticky: unsupported instruction
Timeout  output  1  sticky: memory wait exceeded MAX_WAIT

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, ERR=15.
- Outputs not listed for a state are 0.
- FETCH: MemReq=1, IorD=0, MemRW=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=0, IRWrite=PCWrite=MemReady. Advance to DECODE only on MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target precomputed into ALUOut). Next state by opcode:
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 0000011 with Funct3=010 -> MEMADR
  - 0100011 with Funct3=010 -> MEMADR
  - 1100011 with Funct3=000 -> BEQ
  - anything else -> ERR, Illegal<=1
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Load -> MEMRD, store -> MEMWR. The opcode is re-read from IR, which is stable.
- MEMRD: MemReq=1, IorD=1, MemRW=0. On MemReady -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1 -> FETCH.
- MEMWR: MemReq=1, IorD=1, MemRW=1. On MemReady -> FETCH.
- EXECR: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECI: ALUSrcA=1, ALUSrcB=10, ALUOp=11 -> ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0 -> FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=Zero -> FETCH.
- ERR: all outputs 0 except Halt=1 and the sticky flags. Holds until RST.
- Latency, with MemReady tied high:
  - R-type, I-type, SW: 4 cycles
  - LW: 5 cycles
  - BEQ: 3 cycles
  - Each low-MemReady cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Wait counter:
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with MemReady=0.
  - Clears on every state change.
  - If the counter equals MAX_WAIT while MemReady=0 -> ERR, Timeout<=1.
  - MemReady=1 in the same cycle the counter reaches MAX_WAIT completes the access normally; no timeout.
- MemReady outside a memory state is ignored.
- Reset, including mid-access or in ERR:
  - State<=FETCH; wait counter, Illegal, Timeout, Halt <=0.
  - The outputs in the first cycle after reset are the FETCH values (MemReq=1).
  - Any in-flight access is abandoned with no PC or register write.

Test Plan:
- RST high 2 cycles, release; MemReady=1, Opcode=0110011 -> State 0,1,6,8,0. RegWrite=1 only in state 8 with MemtoReg=0. PCWrite=1 only in state 0. ALUOp=10 in state 6.
- LW (0000011, Funct3=010), MemReady low 3 cycles in MEMRD -> State 0,1,2,3,3,3,3,4,0. MemReq=1, IorD=1 for 4 cycles. RegWrite=1 with MemtoReg=1 in state 4. Timeout=0.
- BEQ (1100011, Funct3=000) with Zero=1, then again with Zero=0 -> 3 cycles each. PCWrite=1 and PCSrc=1 in state 9 for the first; PCWrite=0 in state 9 for the second.
- Opcode=1101111 in DECODE -> State=15 next cycle with Illegal=1 and Halt=1. All enables stay 0 for 10 cycles until RST, then State=0 and flags clear.
- MAX_WAIT=15, MemReady held 0 in FETCH -> stays in state 0 for 15 cycles, then State=15 with Timeout=1. A repeat run with MemReady=1 on the 15th wait cycle -> DECODE, no timeout.
- SW in MEMWR with MemReady=0, RST asserted -> next cycle State=0, MemRW=0, no PCWrite or RegWrite pulse observed.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control                                                       |
// | Moore sequencer for the multi-cycle RV32I-subset datapath.               |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module multicycle_control #(
  parameter int MAX_WAIT = 15,
  parameter int WAITW    = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemRW,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic [3:0] State,
  output logic       Halt,
  output logic       Illegal,
  output logic       Timeout
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_ERR    = 4'd15
  } state_t;

  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [2:0] c_f3_word   = 3'b010;
  localparam logic [2:0] c_f3_beq    = 3'b000;

  // The timeout fires on the MAX_WAIT-th consecutive stalled cycle.
  localparam logic [WAITW-1:0] c_wait_last = WAITW'(MAX_WAIT - 1);

  state_t           state_q, state_d;
  logic [WAITW-1:0] wait_q, wait_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             mem_state;
  logic             stalled;

  always_comb begin
    MemReq    = 1'b0;
    MemRW     = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    RegWrite  = 1'b0;
    MemtoReg  = 1'b0;
    Halt      = 1'b0;
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;

    mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    stalled   = mem_state && !MemReady;

    case (state_q)
      S_FETCH: begin
        MemReq  = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b10;
        if (Opcode == c_op_rtype)
          state_d = S_EXECR;
        else if (Opcode == c_op_itype)
          state_d = S_EXECI;
        else if ((Opcode == c_op_load || Opcode == c_op_store) && Funct3 == c_f3_word)
          state_d = S_MEMADR;
        else if (Opcode == c_op_branch && Funct3 == c_f3_beq)
          state_d = S_BEQ;
        else begin
          state_d   = S_ERR;
          illegal_d = 1'b1;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Opcode == c_op_load) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        MemRW  = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b01;
        PCSrc   = 1'b1;
        PCWrite = Zero;
        state_d = S_FETCH;
      end
      S_ERR: begin
        Halt = 1'b1;
      end
      default: begin
        // Unused codes are treated as a fault and park the core.
        Halt    = 1'b1;
        state_d = S_ERR;
      end
    endcase

    if (stalled && wait_q == c_wait_last) begin
      state_d   = S_ERR;
      timeout_d = 1'b1;
    end

    if (state_d != state_q)
      wait_d = '0;
    else if (stalled)
      wait_d = wait_q + WAITW'(1);
    else
      wait_d = wait_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign State   = state_q;
  assign Illegal = illegal_q;
  assign Timeout = timeout_q;

endmodule
`default_nettype wire
